bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive GRANT cycles before forced release (range 2..255; used only with BUS_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  bus requests; bit i = master i (A=0, B=1, C=2, D=3).
REQ-005 grant  output  4  one-hot bus grant, registered.
REQ-006 sel  output  2  binary index of current/last owner; drives the downstream 4-source bus mux select S.
REQ-007 bus_busy  output  1  high while any grant bit is high.
REQ-008 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, GRANT, TURN.
REQ-010 IDLE: if req!=0, the next edge SHALL enter GRANT and assert grant for the winner; if req==0, remain in IDLE.
- Request-to-grant latency: 1 clock.
REQ-011 The winner SHALL be chosen round-robin: first set req bit scanning from (last+1) mod 4 upward with wrap 3->0.
- last = index of the most recent owner.
REQ-012 On entry to GRANT, sel SHALL load the winner index and last SHALL update to it.
REQ-013 GRANT: while req[owner]=1, the FSM SHALL hold grant, sel and bus_busy unchanged.
- Other requesters' bits SHALL be ignored.
REQ-014 GRANT: req[owner]=0 SHALL move the FSM to TURN on the next edge.
REQ-015 TURN SHALL last exactly one cycle with grant=0 and bus_busy=0, then return to IDLE.
- Minimum owner-to-owner gap: 2 cycles.
REQ-016 In IDLE and TURN, sel SHALL hold its last value so the downstream bus stays stable.
REQ-017 grant SHALL never have more than one bit set.
- bus_busy SHALL equal |grant in every cycle.
REQ-018 If req changes on the same edge the FSM samples it, the registered (pre-edge) value SHALL be used; no combinational path from req to any output.

Reset
REQ-019 rst_n low SHALL immediately, without waiting for clk, force:
- state=IDLE, grant=0000, sel=00, bus_busy=0, timeout=0, hold counter=0;
- last=3, so master 0 has first priority.
REQ-020 Reset asserted during GRANT SHALL drop grant without a TURN cycle.
- After reset release, arbitration SHALL restart from master 0 priority.
REQ-021 The first arbitration SHALL occur on the first rising edge with rst_n high.

Configuration
REQ-022 Macro BUS_ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on GRANT entry and increment each GRANT cycle.
- Counter = MAX_HOLD-1 with another req bit pending: next edge SHALL go to TURN and pulse timeout high for that one TURN cycle.
- Counter = MAX_HOLD-1 with no other request pending: the counter SHALL saturate and the owner SHALL keep the bus.
- After a forced release, the released master SHALL rank last in the next round-robin.
REQ-023 Macro BUS_ARB_TIMEOUT_EN undefined: no counter SHALL be built, timeout SHALL be tied 0, and ownership SHALL end only by req drop.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- V1: reset, req=0001 held 3 cycles then 0000 -> grant=0001 and sel=00 one edge after req; 3 GRANT cycles; 1 TURN cycle (grant=0000); IDLE.
- V2: req=1111 held constant, each owner drops its bit for one cycle after 2 cycles of ownership -> sel sequence 00,01,10,11,00; exactly one TURN between owners.
- V3: after master 2 (sel=10) releases, req=0011 -> next owner master 0 (sel=00, wrap), not master 1.
- V4: reset pulse mid-GRANT (sel=10) -> grant=0000, sel=00 before next clk edge; then req=1100 -> master 2 granted (last reset to 3).
- V5 (BUS_ARB_TIMEOUT_EN, MAX_HOLD=4): req=0011 held constant -> master 0 granted 4 cycles, timeout=1 for one cycle, master 1 granted.
  - Same stimulus with macro undefined: master 0 holds indefinitely, timeout stays 0.
- V6: req=0100 alone with timeout enabled, held 20 cycles -> no forced release, timeout never 1.

Source files
------------

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with IDLE/GRANT/TURN handshake and registered one-hot grant.
// Optional forced release after MAX_HOLD grant cycles when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       bus_busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [1:0] winner;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  // First requester after the previous owner, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    winner    = rr_pick(req, last_q);
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          last_d  = winner;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          state_d = TURN;
          grant_d = 4'b0000;
`ifdef BUS_ARB_TIMEOUT_EN
        end else if (hold_q == HOLD_LAST) begin
          // Counter saturates here; the owner keeps the bus unless someone else waits.
          if ((req & ~grant_q) != 4'b0000) begin
            state_d   = TURN;
            grant_d   = 4'b0000;
            timeout_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign bus_busy = |grant_q;
`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule
